// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction fetch bridge and its address mapper.
// Covers the fetch FSM encodings, the bus transfer size and the kseg0/kseg1 mask.
package inst_fetch_bridge_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_ADDR    = 2'd1,
      FETCH_DATA    = 2'd2,
      FETCH_DISCARD = 2'd3
   } fetch_state_t;

   localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

   // pc[31:30]==2'b10 selects kseg0/kseg1; both map to physical by clearing [31:29].
   localparam logic [1:0]  KSEG_SEG_BITS  = 2'b10;
   localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/fetch_addr_map.sv
// Combinational virtual-to-physical mapper for unmapped kernel segments.
// Also reused by the data-side bridge.
module fetch_addr_map
   import inst_fetch_bridge_pkg::*;
#(
   parameter logic ADDR_MAP_EN = 1'b1
) (
   input  logic [31:0] i_vaddr,
   output logic [31:0] o_paddr
);

   logic w_kseg;

   assign w_kseg  = ADDR_MAP_EN && (i_vaddr[31:30] == KSEG_SEG_BITS);
   assign o_paddr = w_kseg ? (i_vaddr & KSEG_PHYS_MASK) : i_vaddr;

endmodule

// File: rtl/inst_fetch_bridge.sv
// Bridge from the core fetch port to an SRAM-like req/addr_ok/data_ok instruction bus.
// One outstanding read; returned words are forwarded same-cycle or buffered until consumed.
module inst_fetch_bridge
   import inst_fetch_bridge_pkg::*;
#(
   parameter logic ADDR_MAP_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   input  logic        if_stall,
   input  logic        if_flush,
   output logic [31:0] if_instr,
   output logic        stallreq_from_if,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_wdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [1:0]  dbg_state
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;
   logic [31:0]  r_req_pc;
   logic         r_buf_valid;
   logic [31:0]  r_buf_pc;
   logic [31:0]  r_buf_instr;
   logic         w_buf_valid_nxt;
   logic         w_aligned;
   logic         w_buf_hit;
   logic         w_bypass;
   logic         w_pending;
   logic [31:0]  w_paddr;

   fetch_addr_map #(.ADDR_MAP_EN(ADDR_MAP_EN)) u_addr_map (
      .i_vaddr (r_req_pc),
      .o_paddr (w_paddr)
   );

   assign w_aligned = (if_pc[1:0] == 2'b00);
   assign w_buf_hit = r_buf_valid && (r_buf_pc == if_pc);
   assign w_bypass  = (r_state == FETCH_DATA) && inst_data_ok && (r_req_pc == if_pc);
   assign w_pending = w_aligned && !w_buf_hit && !w_bypass;

   assign stallreq_from_if = w_pending;
   assign if_instr   = w_bypass  ? inst_rdata  :
                       w_buf_hit ? r_buf_instr : 32'h0;
   assign inst_req   = (r_state == FETCH_ADDR);
   // r_req_pc only changes on leaving IDLE, so the address is stable until addr_ok.
   assign inst_addr  = w_paddr;
   assign inst_wr    = 1'b0;
   assign inst_size  = INST_SIZE_WORD;
   assign inst_wdata = 32'h0;
   assign dbg_state  = r_state;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         FETCH_IDLE: begin
            if (w_pending && !if_flush) w_next_state = FETCH_ADDR;
         end
         FETCH_ADDR: begin
            if (inst_addr_ok)  w_next_state = if_flush ? FETCH_DISCARD : FETCH_DATA;
            else if (if_flush) w_next_state = FETCH_IDLE;
         end
         FETCH_DATA: begin
            if (inst_data_ok)  w_next_state = FETCH_IDLE;
            else if (if_flush) w_next_state = FETCH_DISCARD;
         end
         FETCH_DISCARD: begin
            if (inst_data_ok) w_next_state = FETCH_IDLE;
         end
         default: w_next_state = FETCH_IDLE;
      endcase
   end

   // A word forwarded and consumed in its arrival cycle never occupies the buffer.
   always_comb begin
      w_buf_valid_nxt = r_buf_valid;
      if (if_flush)
         w_buf_valid_nxt = 1'b0;
      else if ((r_state == FETCH_DATA) && inst_data_ok)
         w_buf_valid_nxt = !(w_bypass && !if_stall);
      else if (w_buf_hit && !if_stall)
         w_buf_valid_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= FETCH_IDLE;
         r_req_pc    <= 32'h0;
         r_buf_valid <= 1'b0;
         r_buf_pc    <= 32'h0;
         r_buf_instr <= 32'h0;
      end else begin
         r_state     <= w_next_state;
         r_buf_valid <= w_buf_valid_nxt;
         if ((r_state == FETCH_IDLE) && (w_next_state == FETCH_ADDR))
            r_req_pc <= if_pc;
         if ((r_state == FETCH_DATA) && inst_data_ok) begin
            r_buf_instr <= inst_rdata;
            r_buf_pc    <= r_req_pc;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: driver tasks set core and bus inputs per cycle,
// a negedge monitor checks accepted bus addresses and delivered instructions against queues.
module tb_inst_fetch_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_stall;
   logic        if_flush;
   logic [31:0] if_instr;
   logic        stallreq_from_if;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   logic [31:0] addr_q[$];

   inst_fetch_bridge #(.ADDR_MAP_EN(1'b1)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .if_stall         (if_stall),
      .if_flush         (if_flush),
      .if_instr         (if_instr),
      .stallreq_from_if (stallreq_from_if),
      .inst_req         (inst_req),
      .inst_wr          (inst_wr),
      .inst_size        (inst_size),
      .inst_addr        (inst_addr),
      .inst_wdata       (inst_wdata),
      .inst_addr_ok     (inst_addr_ok),
      .inst_data_ok     (inst_data_ok),
      .inst_rdata       (inst_rdata),
      .dbg_state        (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic core(input logic [31:0] pc, input logic st, input logic fl);
      if_pc    = pc;
      if_stall = st;
      if_flush = fl;
   endtask

   task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
      inst_addr_ok = aok;
      inst_data_ok = dok;
      inst_rdata   = rd;
   endtask

   task automatic expect_fetch(input logic [31:0] paddr, input logic [31:0] pc, input logic [31:0] instr);
      addr_q.push_back(paddr);
      exp_q.push_back({pc, instr});
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         if (inst_req && inst_addr_ok) begin
            if (addr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL bus_addr: unexpected accepted request addr %h", inst_addr);
            end else begin
               chk("bus_addr", {32'h0, inst_addr}, {32'h0, addr_q.pop_front()});
            end
         end
         if (!stallreq_from_if && (if_pc[1:0] == 2'b00) && !if_stall && !if_flush) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL deliver: unexpected pc %h instr %h", if_pc, if_instr);
            end else begin
               chk("deliver", {if_pc, if_instr}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      core(32'hBFC0_0000, 1'b0, 1'b0);
      bus(1'b0, 1'b0, 32'h0);
      #4;
      chk("rst_req",   {63'h0, inst_req}, 64'h0);
      chk("rst_addr",  {32'h0, inst_addr}, 64'h0);
      chk("rst_instr", {32'h0, if_instr}, 64'h0);
      chk("rst_state", {62'h0, dbg_state}, 64'h0);
      chk("rst_const", {29'h0, inst_wr, inst_size, inst_wdata}, {29'h0, 1'b0, 2'b10, 32'h0});
      cyc();
      cyc();
      rst = 1'b1;

      // single fetch with bypass
      expect_fetch(32'h1FC0_0000, 32'hBFC0_0000, 32'h3C08_0001);
      settle(); chk("f1_stall0", {63'h0, stallreq_from_if}, 64'h1);
      chk("f1_req0", {63'h0, inst_req}, 64'h0);
      cyc(); bus(1'b1, 1'b0, 32'h0);
      settle(); chk("f1_req1", {63'h0, inst_req}, 64'h1);
      chk("f1_stall1", {63'h0, stallreq_from_if}, 64'h1);
      cyc(); bus(1'b0, 1'b0, 32'h0);
      settle(); chk("f1_stall2", {63'h0, stallreq_from_if}, 64'h1);
      chk("f1_state_data", {62'h0, dbg_state}, 64'h2);
      cyc(); bus(1'b0, 1'b1, 32'h3C08_0001);
      settle(); chk("f1_stall3", {63'h0, stallreq_from_if}, 64'h0);
      chk("f1_instr", {32'h0, if_instr}, {32'h0, 32'h3C08_0001});

      // data arrives while IF is stalled: buffered
      cyc(); bus(1'b0, 1'b0, 32'h0); core(32'hBFC0_0004, 1'b0, 1'b0);
      expect_fetch(32'h1FC0_0004, 32'hBFC0_0004, 32'h2409_0002);
      settle(); chk("f2_stall0", {63'h0, stallreq_from_if}, 64'h1);
      cyc(); bus(1'b1, 1'b0, 32'h0);
      cyc(); bus(1'b0, 1'b0, 32'h0); core(32'hBFC0_0004, 1'b1, 1'b0);
      cyc(); bus(1'b0, 1'b1, 32'h2409_0002);
      settle(); chk("f2_bypass_stall", {63'h0, stallreq_from_if}, 64'h0);
      cyc(); bus(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("f2_held_stall", {63'h0, stallreq_from_if}, 64'h0);
         chk("f2_held_instr", {32'h0, if_instr}, {32'h0, 32'h2409_0002});
         chk("f2_held_noreq", {63'h0, inst_req}, 64'h0);
         cyc();
      end
      core(32'hBFC0_0004, 1'b0, 1'b0);
      settle(); chk("f2_consume", {32'h0, if_instr}, {32'h0, 32'h2409_0002});

      // flush while in DATA, stale word discarded
      cyc(); core(32'hBFC0_0100, 1'b0, 1'b0);
      addr_q.push_back(32'h1FC0_0100);
      settle(); chk("f3_stall0", {63'h0, stallreq_from_if}, 64'h1);
      cyc(); bus(1'b1, 1'b0, 32'h0);
      cyc(); bus(1'b0, 1'b0, 32'h0); core(32'hBFC0_0380, 1'b0, 1'b1);
      cyc(); core(32'hBFC0_0380, 1'b0, 1'b0);
      settle(); chk("f3_discard_stall", {63'h0, stallreq_from_if}, 64'h1);
      chk("f3_discard_noreq", {63'h0, inst_req}, 64'h0);
      chk("f3_state_discard", {62'h0, dbg_state}, 64'h3);
      cyc(); bus(1'b0, 1'b1, 32'hDEAD_BEEF);
      settle(); chk("f3_stale_stall", {63'h0, stallreq_from_if}, 64'h1);
      chk("f3_stale_instr", {32'h0, if_instr}, 64'h0);
      cyc(); bus(1'b0, 1'b0, 32'h0);
      expect_fetch(32'h1FC0_0380, 32'hBFC0_0380, 32'h4080_6000);
      settle(); chk("f3_refetch_stall", {63'h0, stallreq_from_if}, 64'h1);
      chk("f3_state_idle", {62'h0, dbg_state}, 64'h0);
      cyc(); bus(1'b1, 1'b0, 32'h0);
      cyc(); bus(1'b0, 1'b0, 32'h0);
      cyc(); bus(1'b0, 1'b1, 32'h4080_6000);
      settle(); chk("f3_done", {63'h0, stallreq_from_if}, 64'h0);

      // flush in ADDR without addr_ok
      cyc(); bus(1'b0, 1'b0, 32'h0); core(32'hBFC0_0200, 1'b0, 1'b0);
      cyc(); core(32'hBFC0_0300, 1'b0, 1'b1);
      settle(); chk("f4_req_flush", {63'h0, inst_req}, 64'h1);
      chk("f4_addr", {32'h0, inst_addr}, {32'h0, 32'h1FC0_0200});
      cyc(); core(32'hBFC0_0300, 1'b0, 1'b0);
      expect_fetch(32'h1FC0_0300, 32'hBFC0_0300, 32'h3C1D_8000);
      settle(); chk("f4_req_dropped", {63'h0, inst_req}, 64'h0);
      chk("f4_stall", {63'h0, stallreq_from_if}, 64'h1);
      cyc(); bus(1'b1, 1'b0, 32'h0);
      settle(); chk("f4_req_new", {63'h0, inst_req}, 64'h1);
      cyc(); bus(1'b0, 1'b0, 32'h0);
      cyc(); bus(1'b0, 1'b1, 32'h3C1D_8000);

      // misaligned PC
      cyc(); bus(1'b0, 1'b0, 32'h0); core(32'hBFC0_0002, 1'b0, 1'b0);
      settle(); chk("f5_req", {63'h0, inst_req}, 64'h0);
      chk("f5_stall", {63'h0, stallreq_from_if}, 64'h0);
      chk("f5_instr", {32'h0, if_instr}, 64'h0);
      cyc();
      settle(); chk("f5_req_later", {63'h0, inst_req}, 64'h0);
      chk("f5_stall_later", {63'h0, stallreq_from_if}, 64'h0);

      // async reset during DATA
      cyc(); core(32'hBFC0_0400, 1'b0, 1'b0);
      addr_q.push_back(32'h1FC0_0400);
      cyc(); bus(1'b1, 1'b0, 32'h0);
      cyc(); bus(1'b0, 1'b0, 32'h0);
      #1; chk("f6_in_data", {62'h0, dbg_state}, 64'h2);
      #1; rst = 1'b0;
      #1;
      chk("f6_rst_req",   {63'h0, inst_req}, 64'h0);
      chk("f6_rst_instr", {32'h0, if_instr}, 64'h0);
      chk("f6_rst_addr",  {32'h0, inst_addr}, 64'h0);
      chk("f6_rst_state", {62'h0, dbg_state}, 64'h0);
      core(32'h8000_0000, 1'b0, 1'b0);
      cyc();
      cyc();
      rst = 1'b1;
      expect_fetch(32'h0000_0000, 32'h8000_0000, 32'h2402_0005);
      settle(); chk("f6_stall", {63'h0, stallreq_from_if}, 64'h1);
      cyc(); bus(1'b1, 1'b0, 32'h0);
      settle(); chk("f6_req", {63'h0, inst_req}, 64'h1);
      chk("f6_addr", {32'h0, inst_addr}, 64'h0);
      cyc(); bus(1'b0, 1'b0, 32'h0);
      cyc(); bus(1'b0, 1'b1, 32'h2402_0005);
      cyc(); bus(1'b0, 1'b0, 32'h0); core(32'h8000_0002, 1'b1, 1'b0);
      cyc();
      cyc();

      chk("exp_q_empty",  {32'h0, 32'(exp_q.size())}, 64'h0);
      chk("addr_q_empty", {32'h0, 32'(addr_q.size())}, 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
